// File: rtl/dbg_pkg.sv
// Shared types and sizing for the register-file dump reader.
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } dump_state_e;

  localparam int unsigned DEFAULT_XLEN  = 64;
  localparam int unsigned BYTES_PER_REG = DEFAULT_XLEN / 8;
  localparam int unsigned REG_IDX_W     = 5;

  // A single-byte word still needs a one-bit index register.
  function automatic int unsigned byte_idx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/reg_byte_serializer.sv
// Captures one XLEN word and emits it LSB-first as bytes under valid/ready.
module reg_byte_serializer
  import dbg_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [7:0]      data_o,
  output logic            last_byte_o,
  output logic            fire_o
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned BIDX_W = byte_idx_width(NBYTES);

  logic [XLEN-1:0]   shift_q, shift_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic              valid_q, valid_d;
  logic              last_byte;
  logic              fire;

  assign last_byte = (byte_idx_q == BIDX_W'(NBYTES - 1));
  assign fire      = valid_q & ready_i;

  always_comb begin
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    valid_d    = valid_q;
    if (load_i) begin
      shift_d    = data_i;
      byte_idx_d = '0;
      valid_d    = 1'b1;
    end else if (fire) begin
      shift_d = shift_q >> 8;
      if (last_byte) begin
        valid_d = 1'b0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      valid_q    <= valid_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = shift_q[7:0];
  assign last_byte_o = last_byte;
  assign fire_o      = fire;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG through an async read port and
// streams each captured value out as little-endian bytes.
module regfile_dump_reader
  import dbg_pkg::*;
#(
  parameter int unsigned XLEN      = DEFAULT_XLEN,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [REG_IDX_W-1:0] rf_addr,
  input  logic [XLEN-1:0]      rf_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

  dump_state_e          state_q, state_d;
  logic [REG_IDX_W-1:0] reg_idx_q, reg_idx_d;
  logic [REG_IDX_W-1:0] rf_addr_q, rf_addr_d;
  logic                 ser_load;
  logic                 ser_last_byte;
  logic                 ser_fire;

  // rf_addr is registered on entry to LOAD so the read port is settled for
  // the whole LOAD cycle and simply holds afterwards.
  always_comb begin
    state_d   = state_q;
    reg_idx_d = reg_idx_q;
    rf_addr_d = rf_addr_q;
    ser_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          reg_idx_d = FIRST_IDX;
          rf_addr_d = FIRST_IDX;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_fire && ser_last_byte) begin
          if (reg_idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            reg_idx_d = reg_idx_q + 1'b1;
            rf_addr_d = reg_idx_q + 1'b1;
            state_d   = LOAD;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reg_idx_q <= '0;
      rf_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
      rf_addr_q <= rf_addr_d;
    end
  end

  reg_byte_serializer #(
    .XLEN(XLEN)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .data_i     (rf_data),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .last_byte_o(ser_last_byte),
    .fire_o     (ser_fire)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign rf_addr  = rf_addr_q;
  assign out_last = (state_q == SEND) && (reg_idx_q == LAST_IDX) && ser_last_byte;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench: full-range and single-register readers
// compared against a byte-stream model built from the register array.
module tb_regfile_dump_reader;
  import dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        out_ready;
  logic        busy_a, done_a, out_valid_a, out_last_a;
  logic        busy_b, done_b, out_valid_b, out_last_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [63:0] rf_data_a, rf_data_b;
  logic [7:0]  out_data_a, out_data_b;

  logic [63:0] rf [32];

  assign rf_data_a = (rf_addr_a == 5'd0) ? 64'd0 : rf[rf_addr_a];
  assign rf_data_b = (rf_addr_b == 5'd0) ? 64'd0 : rf[rf_addr_b];

  always #5 clk = ~clk;

  regfile_dump_reader #(.XLEN(64), .FIRST_REG(0), .LAST_REG(31)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a)
  );

  regfile_dump_reader #(.XLEN(64), .FIRST_REG(5), .LAST_REG(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b)
  );

  logic       sel;
  logic       mon_valid, mon_last, mon_busy, mon_done;
  logic [7:0] mon_data;
  assign mon_valid = sel ? out_valid_b : out_valid_a;
  assign mon_last  = sel ? out_last_b  : out_last_a;
  assign mon_busy  = sel ? busy_b      : busy_a;
  assign mon_done  = sel ? done_b      : done_a;
  assign mon_data  = sel ? out_data_b  : out_data_a;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int   last_idx, last_count, done_count, done_cyc, last_hs_cyc;
  int   busy_cycles, busy_after_done, stable_err;
  bit   done_gap_ok;
  logic rst_valid, rst_busy, rst_done;

  task automatic build_expected(input int first, input int last);
    logic [63:0] v;
    exp_q.delete();
    for (int r = first; r <= last; r++) begin
      v = (r == 0) ? 64'd0 : rf[r];
      for (int b = 0; b < int'(BYTES_PER_REG); b++)
        exp_q.push_back(8'((v >> (8 * b)) & 64'hFF));
    end
  endtask

  // Runs one dump on the selected reader, recording every accepted byte and
  // timing facts; optional hooks inject stray starts, writes or a reset.
  task automatic do_dump(input bit use_b, input int ready_pct, input int mid_start_cyc,
                         input bit start_on_done, input int rst_after, input int write3_at,
                         input int max_cycles);
    int         cyc;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         wrote;
    got_q.delete();
    last_idx = -1; last_count = 0; done_count = 0; done_cyc = -1; last_hs_cyc = -10;
    busy_cycles = 0; busy_after_done = 0; stable_err = 0; done_gap_ok = 1'b0;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0; wrote = 1'b0;
    sel = use_b;
    out_ready = 1'b0;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < max_cycles) begin
      if (rst_after > 0 && got_q.size() == rst_after) begin
        #2 rst = 1'b1;
        #1;
        rst_valid = mon_valid; rst_busy = mon_busy; rst_done = mon_done;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0; start_a = 1'b0; start_b = 1'b0;
        return;
      end
      start_a = 1'b0; start_b = 1'b0;
      if (mon_busy) begin
        busy_cycles++;
        if (done_cyc >= 0) busy_after_done++;
      end
      if (prev_stall && (!mon_valid || mon_data !== prev_data || mon_last !== prev_last))
        stable_err++;
      if (mon_done) begin
        done_count++;
        if (done_cyc < 0) begin
          done_cyc    = cyc;
          done_gap_ok = (cyc == last_hs_cyc + 1);
        end
        if (start_on_done) begin
          if (use_b) start_b = 1'b1; else start_a = 1'b1;
        end
      end
      out_ready  = ($urandom_range(99) < ready_pct);
      prev_stall = mon_valid && !out_ready;
      prev_data  = mon_data;
      prev_last  = mon_last;
      if (mon_valid && out_ready) begin
        if (mon_last) begin
          last_idx = got_q.size();
          last_count++;
        end
        got_q.push_back(mon_data);
        last_hs_cyc = cyc;
      end
      if (cyc == mid_start_cyc) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (write3_at >= 0 && !wrote && got_q.size() == write3_at) begin
        rf[3] = ~rf[3];
        wrote = 1'b1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 12) break;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; out_ready = 1'b0; sel = 1'b0;
    for (int r = 0; r < 32; r++) rf[r] = 64'd0;
    repeat (2) @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done_a); end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid_a); end
    total++; if (out_data_a !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", out_data_a); end
    total++; if (out_last_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b expected 0", out_last_a); end
    total++; if (rf_addr_a !== 5'd0) begin bad++; $display("[TB] FAIL reset_rf_addr: got %0d expected 0", rf_addr_a); end
    total++; if (busy_b !== 1'b0 || out_valid_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_b: busy %b valid %b expected 0 0", busy_b, out_valid_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    for (int r = 0; r < 32; r++) rf[r] = 64'd0;
    rf[1] = 64'd4; rf[6] = 64'd1; rf[7] = 64'd2;
    build_expected(0, 31);
    do_dump(1'b0, 100, -1, 1'b0, 0, -1, 1000);
    total++; if (got_q.size() !== 256) begin bad++; $display("[TB] FAIL full_count: got %0d expected 256", got_q.size()); end
    if (got_q.size() == 256) begin
      total++; if (got_q[8] !== 8'h04) begin bad++; $display("[TB] FAIL full_byte8: got %h expected 04", got_q[8]); end
      total++; if (got_q[48] !== 8'h01) begin bad++; $display("[TB] FAIL full_byte48: got %h expected 01", got_q[48]); end
      total++; if (got_q[56] !== 8'h02) begin bad++; $display("[TB] FAIL full_byte56: got %h expected 02", got_q[56]); end
      for (int i = 0; i < 256; i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL full_stream[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    total++; if (last_idx !== 255 || last_count !== 1) begin bad++; $display("[TB] FAIL full_last: idx %0d count %0d expected 255 1", last_idx, last_count); end
    total++; if (done_count !== 1) begin bad++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_count); end
    total++; if (done_gap_ok !== 1'b1) begin bad++; $display("[TB] FAIL full_done_gap: got %b expected 1", done_gap_ok); end
    total++; if (done_cyc !== 288) begin bad++; $display("[TB] FAIL full_latency: done at cycle %0d expected 288", done_cyc); end
    total++; if (busy_cycles !== 289) begin bad++; $display("[TB] FAIL full_busy_cycles: got %0d expected 289", busy_cycles); end
  endtask

  task automatic test_single_reg();
    logic [7:0] want [8];
    want = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    rf[5] = 64'h0123456789ABCDEF;
    do_dump(1'b1, 100, -1, 1'b0, 0, -1, 200);
    total++; if (got_q.size() !== 8) begin bad++; $display("[TB] FAIL single_count: got %0d expected 8", got_q.size()); end
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got_q[i] !== want[i]) begin bad++; $display("[TB] FAIL single_byte[%0d]: got %h expected %h", i, got_q[i], want[i]); end
      end
    end
    total++; if (last_idx !== 7 || last_count !== 1) begin bad++; $display("[TB] FAIL single_last: idx %0d count %0d expected 7 1", last_idx, last_count); end
    total++; if (busy_cycles !== 10) begin bad++; $display("[TB] FAIL single_busy: got %0d expected 10", busy_cycles); end
    total++; if (done_count !== 1) begin bad++; $display("[TB] FAIL single_done: got %0d expected 1", done_count); end
  endtask

  task automatic test_random_ready();
    int mism;
    for (int r = 1; r < 32; r++) rf[r] = {$urandom, $urandom};
    rf[0] = {$urandom, $urandom};
    build_expected(0, 31);
    do_dump(1'b0, 30, -1, 1'b0, 0, -1, 5000);
    mism = 0;
    total++; if (got_q.size() !== 256) begin bad++; $display("[TB] FAIL rand_count: got %0d expected 256", got_q.size()); end
    if (got_q.size() == 256)
      for (int i = 0; i < 256; i++) if (got_q[i] !== exp_q[i]) mism++;
    total++; if (mism !== 0) begin bad++; $display("[TB] FAIL rand_stream: %0d byte errors expected 0", mism); end
    total++; if (stable_err !== 0) begin bad++; $display("[TB] FAIL rand_stable: %0d unstable stalls expected 0", stable_err); end
    total++; if (last_idx !== 255 || last_count !== 1) begin bad++; $display("[TB] FAIL rand_last: idx %0d count %0d expected 255 1", last_idx, last_count); end
    total++; if (done_count !== 1 || done_gap_ok !== 1'b1) begin bad++; $display("[TB] FAIL rand_done: count %0d gap_ok %b expected 1 1", done_count, done_gap_ok); end
  endtask

  task automatic test_back_to_back();
    int mism;
    build_expected(0, 31);
    do_dump(1'b0, 100, 50, 1'b1, 0, -1, 1000);
    mism = 0;
    total++; if (got_q.size() !== 256) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 256", got_q.size()); end
    if (got_q.size() == 256)
      for (int i = 0; i < 256; i++) if (got_q[i] !== exp_q[i]) mism++;
    total++; if (mism !== 0) begin bad++; $display("[TB] FAIL b2b_stream: %0d byte errors expected 0", mism); end
    total++; if (done_count !== 1) begin bad++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", done_count); end
    total++; if (busy_after_done !== 0) begin bad++; $display("[TB] FAIL b2b_restart: busy %0d cycles after done expected 0", busy_after_done); end
  endtask

  task automatic test_reset_mid_dump();
    int mism;
    build_expected(0, 31);
    do_dump(1'b0, 100, -1, 1'b0, 20, -1, 1000);
    total++; if (rst_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", rst_valid); end
    total++; if (rst_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", rst_busy); end
    total++; if (rst_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_done: got %b expected 0", rst_done); end
    total++; if (last_count !== 0 || got_q.size() !== 20) begin bad++; $display("[TB] FAIL rst_mid_partial: last %0d bytes %0d expected 0 20", last_count, got_q.size()); end
    do_dump(1'b0, 100, -1, 1'b0, 0, -1, 1000);
    mism = 0;
    total++; if (got_q.size() !== 256) begin bad++; $display("[TB] FAIL rst_restart_count: got %0d expected 256", got_q.size()); end
    if (got_q.size() == 256)
      for (int i = 0; i < 256; i++) if (got_q[i] !== exp_q[i]) mism++;
    total++; if (mism !== 0) begin bad++; $display("[TB] FAIL rst_restart_stream: %0d byte errors expected 0", mism); end
  endtask

  task automatic test_write_during_send();
    int mism;
    rf[3] = {$urandom, $urandom};
    build_expected(0, 31);
    do_dump(1'b0, 100, -1, 1'b0, 0, 26, 1000);
    mism = 0;
    total++; if (got_q.size() !== 256) begin bad++; $display("[TB] FAIL write_count: got %0d expected 256", got_q.size()); end
    if (got_q.size() == 256)
      for (int i = 24; i < 32; i++) if (got_q[i] !== exp_q[i]) mism++;
    total++; if (mism !== 0) begin bad++; $display("[TB] FAIL write_x3_bytes: %0d byte errors expected 0", mism); end
  endtask

  initial begin
    $display("[TB] starting regfile_dump_reader bench");
    test_reset();
    test_full_dump();
    test_single_reg();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_dump();
    test_write_during_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Hardware reader for the 32x64 integer register file.
- On `start`, walks register indices FIRST_REG..LAST_REG through one asynchronous read port and captures each value.
- Streams each value out as bytes, little-endian, over a valid/ready byte interface to the debug/UART path.
- Replaces the simulation-only hex dump with a synthesizable register-state readout for bring-up.

Parameters:
- XLEN, 64, register width in bits; must be a multiple of 8.
- FIRST_REG, 0, first register index dumped.
- LAST_REG, 31, last register index dumped; FIRST_REG <= LAST_REG <= 31.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin a dump; ignored while busy.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final byte handshake.
- rf_addr  output  5  register index driven onto the register-file read port (rs2).
- rf_data  input  XLEN  asynchronous read data for rf_addr; x0 reads 0.
- out_valid  output  1  byte available on out_data.
- out_ready  input  1  sink accepts byte when high together with out_valid.
- out_data  output  8  current byte.
- out_last  output  1  high with the final byte of the final register.

Behaviour:
- Reset values (asynchronous): state=IDLE, busy=0, done=0, out_valid=0, out_data=0, out_last=0, rf_addr=0, reg_idx=0, byte_idx=0, shift register=0.
- FSM states: IDLE, LOAD, SEND, FINISH.
- IDLE:
  - start=1 at an edge -> reg_idx<=FIRST_REG, state<=LOAD.
  - busy rises in the LOAD cycle.
- LOAD (1 cycle):
  - rf_addr=reg_idx.
  - At the edge, capture rf_data into the XLEN shift register, set byte_idx<=0, go to SEND.
  - Writes to the same register after capture do not alter in-flight bytes.
- SEND:
  - out_valid=1; out_data=shift[7:0] (byte byte_idx).
  - out_data, out_last and out_valid hold stable until the handshake.
  - On out_valid&&out_ready: shift right by 8.
    - If byte_idx < XLEN/8-1: byte_idx++.
    - Else if reg_idx==LAST_REG: go to FINISH.
    - Else reg_idx++ and go to LOAD.
  - No handshake -> hold all state; backpressure may last indefinitely.
- out_last=1 only while in SEND with reg_idx==LAST_REG and byte_idx==XLEN/8-1.
- FINISH (1 cycle): done=1, out_valid=0, busy=0 next; then IDLE.
- Latency: start sampled at edge N -> LOAD during cycle N+1 -> first out_valid in cycle N+2.
  - With out_ready tied high, a full 32-register dump takes 32*(1+8)+1 = 289 cycles from the LOAD entry to done.
- Byte order: within a register, LSB first. Registers go in ascending index order.
- start during busy or FINISH: ignored, with no queuing.
- A start pulse in the same cycle done is high is also ignored; it must be re-asserted in IDLE.
- rst mid-dump: immediate return to reset values; the partial stream is abandoned with no out_last.
- rf_addr stays at its last value outside LOAD; the register-file read has no side effects.

Decomposition:
- Shared package (`dbg_pkg`) holds:
  - state enum {IDLE, LOAD, SEND, FINISH};
  - BYTES_PER_REG = XLEN/8;
  - REG_IDX_W = 5.
- One natural sub-module, reg_byte_serializer:
  - loads an XLEN word;
  - emits BYTES_PER_REG bytes under valid/ready;
  - signals last_byte.
- The top FSM owns reg_idx, rf_addr, busy/done and out_last.

Test Plan:
- Regfile preloaded x1=4, x6=1, x7=2, others 0; FIRST_REG=0, LAST_REG=31; out_ready=1 -> expect:
  - 256 bytes;
  - byte 8 = 0x04, byte 48 = 0x01, byte 56 = 0x02, all other bytes 0x00;
  - out_last on byte 255;
  - done exactly 1 cycle after that handshake.
- x5=64'h0123456789ABCDEF, FIRST_REG=LAST_REG=5 -> bytes EF,CD,AB,89,67,45,23,01; out_last on 0x01; busy for 10 cycles.
- Random out_ready (about 30% duty) on the full dump -> stream identical to the ready=1 run; out_data stable while out_valid&&!out_ready.
- Second start mid-dump, and start coincident with done -> both ignored, single stream, one done pulse.
- Assert rst after 20 accepted bytes -> out_valid, busy and done drop asynchronously; a fresh start then restarts at FIRST_REG byte 0.
- Write x3 via the write port during its SEND phase -> streamed bytes equal the value captured at LOAD.
